// File: rtl/sample_sequencer_az.sv
// sample_sequencer_az: slot scheduler in front of the AZ sample-acquisition block.
// For each active slot it parks the acquisition block with arm low, latches that
// slot's azmux/pc-switch values, arms acquisition, and counts completed hi/lo pairs.
// A pass over the slots runs once, or repeats when continuous_i is set.
// Optional feature macro: SEQ_TIMEOUT_EN adds a RUN-state watchdog that drives err_o.
module sample_sequencer_az #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_W      = 2,
  parameter int CNT_W       = 16,
  parameter int PARK_CYCLES = 4,
  parameter int TIMEOUT_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we_i,
  input  logic [SLOT_W-1:0] cfg_addr_i,
  input  logic [3:0]        cfg_azmux_lo_i,
  input  logic [3:0]        cfg_azmux_hi_i,
  input  logic [1:0]        cfg_pc_hi_i,
  input  logic [CNT_W-1:0]  cfg_npairs_i,
  input  logic [SLOT_W-1:0] cfg_last_slot_i,
  input  logic              run_i,
  input  logic              continuous_i,
  input  logic [2:0]        status_i,
  output logic [3:0]        azmux_lo_val_o,
  output logic [3:0]        azmux_hi_val_o,
  output logic [1:0]        sw_pc_ctl_hi_val_o,
  output logic              arm_trigger_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic [CNT_W-1:0]  pair_count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PARK_W = $clog2(PARK_CYCLES + 1);
  localparam logic [PARK_W-1:0] PARK_LAST = PARK_W'(PARK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PARK  = 3'd1,
    ST_SETUP = 3'd2,
    ST_ARM   = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic [3:0]       tbl_lo_r [NUM_SLOTS];
  logic [3:0]       tbl_hi_r [NUM_SLOTS];
  logic [1:0]       tbl_pc_r [NUM_SLOTS];
  logic [CNT_W-1:0] tbl_n_r  [NUM_SLOTS];

  logic              run_q_r;
  logic              st_q_r;
  logic              st_q2_r;
  logic [PARK_W-1:0] park_cnt_r, park_cnt_s;
  logic [SLOT_W-1:0] slot_r, slot_s;
  logic [CNT_W-1:0]  pair_cnt_r, pair_cnt_s;
  logic [CNT_W-1:0]  npairs_r;
  logic [3:0]        lo_r, hi_r;
  logic [1:0]        pc_r;
  logic              arm_r, busy_r, done_r;
  logic              load_s;
  logic              run_rise_s;
  logic              pair_fall_s;
  state_t            adv_state_s;
  logic [SLOT_W-1:0] adv_slot_s;
  logic [1:0]        status_unused_s;

  // Only bit0 (hi/lo phase) of the acquisition status matters here.
  assign status_unused_s = status_i[2:1];

  assign run_rise_s  = run_i & ~run_q_r;
  // A lo sample has completed when the registered phase bit falls.
  assign pair_fall_s = st_q2_r & ~st_q_r;

`ifdef SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_r;
  logic                 err_r;
  logic                 wd_load_s;
  logic                 err_set_s;
`endif

  // Configuration table: writes accepted in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tbl_lo_r[i] <= 4'd0;
        tbl_hi_r[i] <= 4'd0;
        tbl_pc_r[i] <= 2'd0;
        tbl_n_r[i]  <= '0;
      end
    end else if (cfg_we_i) begin
      tbl_lo_r[cfg_addr_i] <= cfg_azmux_lo_i;
      tbl_hi_r[cfg_addr_i] <= cfg_azmux_hi_i;
      tbl_pc_r[cfg_addr_i] <= cfg_pc_hi_i;
      tbl_n_r[cfg_addr_i]  <= cfg_npairs_i;
    end
  end

  // Input synchronising registers for run edge and status phase edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q_r <= 1'b0;
      st_q_r  <= 1'b0;
      st_q2_r <= 1'b0;
    end else begin
      run_q_r <= run_i;
      st_q_r  <= status_i[0];
      st_q2_r <= st_q_r;
    end
  end

  // Slot advance rule shared by the end of RUN and skipped slots in PARK.
  always_comb begin
    adv_state_s = ST_DONE;
    adv_slot_s  = slot_r;
    if (slot_r < cfg_last_slot_i) begin
      adv_state_s = ST_PARK;
      adv_slot_s  = slot_r + SLOT_W'(1);
    end else if ((slot_r == cfg_last_slot_i) && continuous_i) begin
      adv_state_s = ST_PARK;
      adv_slot_s  = '0;
    end else begin
      adv_state_s = ST_DONE;
      adv_slot_s  = slot_r;
    end
  end

  // Next-state logic; run_i low aborts from any active state with top priority.
  always_comb begin
    state_s    = state_r;
    slot_s     = slot_r;
    pair_cnt_s = pair_cnt_r;
    park_cnt_s = park_cnt_r;
    load_s     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wd_load_s  = 1'b0;
    err_set_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (run_rise_s) begin
          state_s    = ST_PARK;
          slot_s     = '0;
          park_cnt_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PARK: begin
        if (!run_i) begin
          state_s = ST_IDLE;
        end else if (park_cnt_r == PARK_LAST) begin
          park_cnt_s = '0;
          if (tbl_n_r[slot_r] == '0) begin
            state_s = adv_state_s;
            slot_s  = adv_slot_s;
          end else begin
            state_s    = ST_SETUP;
            load_s     = 1'b1;
            pair_cnt_s = '0;
          end
        end else begin
          park_cnt_s = park_cnt_r + PARK_W'(1);
        end
      end
      ST_SETUP: begin
        if (!run_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!run_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
`ifdef SEQ_TIMEOUT_EN
          wd_load_s = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        if (!run_i) begin
          state_s = ST_IDLE;
`ifdef SEQ_TIMEOUT_EN
        end else if (wd_r == '0) begin
          state_s   = ST_IDLE;
          err_set_s = 1'b1;
`endif
        end else if (pair_fall_s) begin
          pair_cnt_s = pair_cnt_r + CNT_W'(1);
`ifdef SEQ_TIMEOUT_EN
          wd_load_s  = 1'b1;
`endif
          if (pair_cnt_s == npairs_r) begin
            state_s    = adv_state_s;
            slot_s     = adv_slot_s;
            park_cnt_s = '0;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      slot_r     <= '0;
      pair_cnt_r <= '0;
      park_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      slot_r     <= slot_s;
      pair_cnt_r <= pair_cnt_s;
      park_cnt_r <= park_cnt_s;
    end
  end

  // Registered outputs; slot values latch on entry to SETUP so they settle before arm rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_r     <= 4'd0;
      hi_r     <= 4'd0;
      pc_r     <= 2'd0;
      npairs_r <= '0;
      arm_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      if (load_s) begin
        lo_r     <= tbl_lo_r[slot_r];
        hi_r     <= tbl_hi_r[slot_r];
        pc_r     <= tbl_pc_r[slot_r];
        npairs_r <= tbl_n_r[slot_r];
      end
      arm_r  <= (state_s == ST_ARM) || (state_s == ST_RUN);
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_DONE);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Watchdog: reloads on RUN entry and each counted pair, counts down while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r <= '0;
    end else if (wd_load_s) begin
      wd_r <= '1;
    end else if (state_r == ST_RUN) begin
      wd_r <= wd_r - TIMEOUT_W'(1);
    end
  end

  // Sticky watchdog error, cleared by a fresh run request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (run_rise_s) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

  assign azmux_lo_val_o     = lo_r;
  assign azmux_hi_val_o     = hi_r;
  assign sw_pc_ctl_hi_val_o = pc_r;
  assign arm_trigger_o      = arm_r;
  assign slot_o             = slot_r;
  assign pair_count_o       = pair_cnt_r;
  assign busy_o             = busy_r;
  assign done_o             = done_r;

endmodule
